io_mmap: RTL and testbench

IO_MMAP -- requirements
Module: io_mmap

---
 rtl/io_pkg.sv | 28 ++
 rtl/io_rx_fifo.sv | 59 +++++
 rtl/io_mmap.sv | 160 ++++++++++++++++
 tb/tb_io_mmap.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared IO-space map: base nibble, register offsets and status bit layout.
// Pure definitions, no logic; also consumed by the memory-control decoder.
// No flow control here.
package io_pkg;

    localparam logic [3:0] IO_BASE_NIBBLE_DEF = 4'b1000;

    localparam logic [7:0] IO_OFF_STATUS  = 8'h00;
    localparam logic [7:0] IO_OFF_RX      = 8'h04;
    localparam logic [7:0] IO_OFF_TX      = 8'h08;
    localparam logic [7:0] IO_OFF_CYCLE   = 8'h10;
    localparam logic [7:0] IO_OFF_INSTR   = 8'h14;
    localparam logic [7:0] IO_OFF_CNT_RST = 8'h18;

    localparam int IO_STAT_TX_READY = 0;
    localparam int IO_STAT_RX_AVAIL = 1;

    typedef struct packed {
        logic [29:0] rsvd;
        logic        rx_avail;
        logic        tx_ready;
    } io_status_t;

    function automatic logic io_hit(input logic [31:0] adr, input logic [3:0] base);
        return adr[31:28] == base;
    endfunction

endpackage

// File: rtl/io_rx_fifo.sv
// UART receive byte FIFO, DEPTH entries (power of 2), pointers wrap modulo depth.
// Latency: pushed byte visible at pop_dat the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; push+pop both apply.
module io_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 push_dat,
    input  logic                       pop,
    output logic [7:0]                 pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_mmap.sv
// Memory-mapped IO block: UART tx/rx registers plus cycle and retired-instruction counters.
// Latency: load data registered, valid the cycle after io_re; stores take effect next cycle.
// Backpressure: tx writes dropped while a byte is pending; rx held off when the buffer is full.
// Optional IO_RX_FIFO_EN: RX_FIFO_DEPTH-entry rx FIFO instead of a single holding byte.
module io_mmap
    import io_pkg::*;
#(
    parameter int         RX_FIFO_DEPTH  = 8,
    parameter logic [3:0] IO_BASE_NIBBLE = IO_BASE_NIBBLE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_adr,
    input  logic [31:0] io_wdata,
    input  logic [3:0]  io_wea,
    input  logic        io_re,
    input  logic        inst_commit,
    output logic [31:0] io_rdata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("io_mmap: RX_FIFO_DEPTH must be a power of 2 and at least 2");
    end

    logic        is_io;
    logic [7:0]  off;
    logic        io_wr;
    logic        io_rd;
    logic        tx_wr;
    logic        cnt_clr;
    logic        rx_rd;
    logic        rx_push;
    logic        rx_pop;
    logic        rx_full;
    logic        rx_avail;
    logic [7:0]  rx_dat;
    logic [31:0] cyc_cnt;
    logic [31:0] ins_cnt;
    logic [31:0] rd_mux;
    io_status_t  status;
    logic        unused_bits;

    assign is_io   = io_hit(io_adr, IO_BASE_NIBBLE);
    assign off     = io_adr[7:0];
    assign io_wr   = is_io && (|io_wea);
    assign io_rd   = is_io && io_re;
    assign tx_wr   = io_wr && (off == IO_OFF_TX);
    assign cnt_clr = io_wr && (off == IO_OFF_CNT_RST);
    assign rx_rd   = io_rd && (off == IO_OFF_RX);

    assign unused_bits = ^{io_adr[27:8], io_wdata[31:8]};

    // Ready depends on buffer state only, never on uart_rx_valid.
    assign uart_rx_ready = !rx_full;
    assign rx_push       = uart_rx_valid && uart_rx_ready;
    assign rx_pop        = rx_rd && rx_avail;

`ifdef IO_RX_FIFO_EN
    logic                           rx_empty;
    logic [7:0]                     rx_head;
    logic [$clog2(RX_FIFO_DEPTH):0] unused_rx_count;

    io_rx_fifo #(
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rx_push),
        .push_dat (uart_rx_data),
        .pop      (rx_pop),
        .pop_dat  (rx_head),
        .full     (rx_full),
        .empty    (rx_empty),
        .count    (unused_rx_count)
    );

    assign rx_avail = !rx_empty;
    assign rx_dat   = rx_head;
`else
    logic       rx_occ;
    logic [7:0] rx_hold;

    // Push needs an empty register and pop needs a full one, so they never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_occ  <= 1'b0;
            rx_hold <= 8'h00;
        end else if (rx_push) begin
            rx_occ  <= 1'b1;
            rx_hold <= uart_rx_data;
        end else if (rx_pop) begin
            rx_occ  <= 1'b0;
        end
    end

    assign rx_full  = rx_occ;
    assign rx_avail = rx_occ;
    assign rx_dat   = rx_hold;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= 8'h00;
        end else if (uart_tx_valid) begin
            if (uart_tx_ready) begin
                uart_tx_valid <= 1'b0;
            end
        end else if (tx_wr) begin
            uart_tx_valid <= 1'b1;
            uart_tx_data  <= io_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cyc_cnt <= 32'h0;
            ins_cnt <= 32'h0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (inst_commit) begin
                ins_cnt <= ins_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        status          = '0;
        status.tx_ready = !uart_tx_valid;
        status.rx_avail = rx_avail;
    end

    always_comb begin
        rd_mux = 32'h0;
        if (is_io) begin
            case (off)
                IO_OFF_STATUS: rd_mux = status;
                IO_OFF_RX:     rd_mux = rx_avail ? {24'h0, rx_dat} : 32'h0;
                IO_OFF_CYCLE:  rd_mux = cyc_cnt;
                IO_OFF_INSTR:  rd_mux = ins_cnt;
                default:       rd_mux = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io_rdata <= 32'h0;
        end else if (io_re) begin
            io_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_io_mmap.sv
// Directed bench for io_mmap: decode/tx vector table, then rx, counter and reset sequences.
module tb_io_mmap;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] io_adr;
    logic [31:0] io_wdata;
    logic [3:0]  io_wea;
    logic        io_re;
    logic        inst_commit;
    logic [31:0] io_rdata;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] A_ST  = 32'h8000_0000;
    localparam logic [31:0] A_RX  = 32'h8000_0004;
    localparam logic [31:0] A_TX  = 32'h8000_0008;
    localparam logic [31:0] A_CYC = 32'h8000_0010;
    localparam logic [31:0] A_INS = 32'h8000_0014;
    localparam logic [31:0] A_CLR = 32'h8000_0018;

    io_mmap dut (
        .clk           (clk),
        .rst           (rst),
        .io_adr        (io_adr),
        .io_wdata      (io_wdata),
        .io_wea        (io_wea),
        .io_re         (io_re),
        .inst_commit   (inst_commit),
        .io_rdata      (io_rdata),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [3:0]  wea;
        logic        re;
        logic        txr;
        logic [31:0] exp_rdata;
        logic        exp_txv;
        logic [7:0]  exp_txd;
    } vec_t;

    localparam int NV = 21;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        io_adr   = a;
        io_wdata = d;
        io_wea   = 4'hF;
        io_re    = 1'b0;
        step();
        io_wea   = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        io_adr = a;
        io_wea = 4'h0;
        io_re  = 1'b1;
        step();
        io_re  = 1'b0;
        d      = io_rdata;
    endtask

    task automatic push(input logic [7:0] b);
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        step();
        uart_rx_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  exp_q [$];

        // adr, wdata, wea, re, tx_ready, exp_rdata, exp_tx_valid, exp_tx_data
        vt[0]  = '{A_ST,         32'h0,         4'h0, 1'b1, 1'b0, 32'h1, 1'b0, 8'h00};
        vt[1]  = '{A_TX,         32'h41,        4'hF, 1'b0, 1'b0, 32'h1, 1'b1, 8'h41};
        vt[2]  = '{A_ST,         32'h0,         4'h0, 1'b1, 1'b0, 32'h0, 1'b1, 8'h41};
        vt[3]  = '{A_ST,         32'h0,         4'h0, 1'b0, 1'b0, 32'h0, 1'b1, 8'h41};
        vt[4]  = '{A_ST,         32'h0,         4'h0, 1'b0, 1'b0, 32'h0, 1'b1, 8'h41};
        vt[5]  = '{A_ST,         32'h0,         4'h0, 1'b0, 1'b1, 32'h0, 1'b0, 8'h00};
        vt[6]  = '{A_ST,         32'h0,         4'h0, 1'b1, 1'b0, 32'h1, 1'b0, 8'h00};
        vt[7]  = '{A_TX,         32'h42,        4'hF, 1'b0, 1'b0, 32'h1, 1'b1, 8'h42};
        vt[8]  = '{A_TX,         32'h43,        4'hF, 1'b0, 1'b0, 32'h1, 1'b1, 8'h42};
        vt[9]  = '{A_ST,         32'h0,         4'h0, 1'b1, 1'b0, 32'h0, 1'b1, 8'h42};
        vt[10] = '{A_ST,         32'h0,         4'h0, 1'b0, 1'b1, 32'h0, 1'b0, 8'h00};
        vt[11] = '{A_ST,         32'h0,         4'h0, 1'b1, 1'b0, 32'h1, 1'b0, 8'h00};
        vt[12] = '{32'h0000_0000, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0, 1'b0, 8'h00};
        vt[13] = '{32'h0000_0008, 32'h99,       4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00};
        vt[14] = '{A_ST,         32'h0,         4'h0, 1'b1, 1'b0, 32'h1, 1'b0, 8'h00};
        vt[15] = '{32'h8000_000C, 32'h0,        4'h0, 1'b1, 1'b0, 32'h0, 1'b0, 8'h00};
        vt[16] = '{32'h8000_0100, 32'h0,        4'h0, 1'b1, 1'b0, 32'h1, 1'b0, 8'h00};
        vt[17] = '{A_TX,         32'h77,        4'h4, 1'b0, 1'b0, 32'h1, 1'b1, 8'h77};
        vt[18] = '{A_RX,         32'h0,         4'h0, 1'b1, 1'b1, 32'h0, 1'b0, 8'h00};
        vt[19] = '{A_TX,         32'hAAAA_AA12, 4'h8, 1'b0, 1'b1, 32'h0, 1'b1, 8'h12};
        vt[20] = '{A_ST,         32'h0,         4'h0, 1'b0, 1'b1, 32'h0, 1'b0, 8'h00};

        rst           = 1'b1;
        io_adr        = 32'h0;
        io_wdata      = 32'h0;
        io_wea        = 4'h0;
        io_re         = 1'b0;
        inst_commit   = 1'b0;
        uart_tx_ready = 1'b0;
        uart_rx_data  = 8'h00;
        uart_rx_valid = 1'b0;
        @(negedge clk);
        step();
        chk("reset rdata", io_rdata, 32'h0);
        chk("reset tx_valid", 32'(uart_tx_valid), 32'h0);
        chk("reset tx_data", 32'(uart_tx_data), 32'h0);
        chk("reset rx_ready", 32'(uart_rx_ready), 32'h1);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            io_adr        = vt[i].adr;
            io_wdata      = vt[i].wdata;
            io_wea        = vt[i].wea;
            io_re         = vt[i].re;
            uart_tx_ready = vt[i].txr;
            step();
            chk($sformatf("vec%0d rdata", i), io_rdata, vt[i].exp_rdata);
            chk($sformatf("vec%0d tx_valid", i), 32'(uart_tx_valid), 32'(vt[i].exp_txv));
            if (vt[i].exp_txv) begin
                chk($sformatf("vec%0d tx_data", i), 32'(uart_tx_data), 32'(vt[i].exp_txd));
            end
        end
        io_wea        = 4'h0;
        io_re         = 1'b0;
        uart_tx_ready = 1'b0;

`ifdef IO_RX_FIFO_EN
        chk("rx ready empty", 32'(uart_rx_ready), 32'h1);
        for (int i = 0; i < 8; i++) begin
            push(8'h10 + 8'(i));
            chk($sformatf("rx ready after push %0d", i), 32'(uart_rx_ready), (i < 7) ? 32'h1 : 32'h0);
        end
        for (int i = 0; i < 8; i++) begin
            rd(A_RX, d);
            chk($sformatf("rx pop %0d", i), d, 32'h10 + 32'(i));
        end
        rd(A_RX, d);
        chk("rx pop empty", d, 32'h0);
        rd(A_ST, d);
        chk("status drained", d, 32'h1);
        for (int i = 0; i < 8; i++) begin
            push(8'h20 + 8'(i));
        end
        chk("rx ready refilled", 32'(uart_rx_ready), 32'h0);
        // Full buffer: push 0x55 offered while popping; refused this cycle, taken next.
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h55;
        io_adr        = A_RX;
        io_re         = 1'b1;
        step();
        io_re = 1'b0;
        chk("full pop data", io_rdata, 32'h20);
        chk("full push refused", 32'(uart_rx_ready), 32'h1);
        step();
        uart_rx_valid = 1'b0;
        chk("retry push taken", 32'(uart_rx_ready), 32'h0);
        rd(A_RX, d);
        chk("pop 0x21", d, 32'h21);
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h66;
        io_adr        = A_RX;
        io_re         = 1'b1;
        step();
        io_re         = 1'b0;
        uart_rx_valid = 1'b0;
        chk("push+pop data", io_rdata, 32'h22);
        chk("push+pop occupancy", 32'(uart_rx_ready), 32'h1);
        exp_q = '{8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h55, 8'h66};
        foreach (exp_q[k]) begin
            rd(A_RX, d);
            chk($sformatf("drain %0d", k), d, 32'(exp_q[k]));
        end
        rd(A_RX, d);
        chk("drain empty", d, 32'h0);
`else
        chk("rx ready empty", 32'(uart_rx_ready), 32'h1);
        push(8'h10);
        chk("rx ready held", 32'(uart_rx_ready), 32'h0);
        push(8'h11);
        rd(A_RX, d);
        chk("rx hold data", d, 32'h10);
        chk("rx ready freed", 32'(uart_rx_ready), 32'h1);
        rd(A_RX, d);
        chk("rx pop empty", d, 32'h0);
        rd(A_ST, d);
        chk("status drained", d, 32'h1);
        push(8'h20);
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h55;
        io_adr        = A_RX;
        io_re         = 1'b1;
        step();
        io_re = 1'b0;
        chk("full pop data", io_rdata, 32'h20);
        chk("full push refused", 32'(uart_rx_ready), 32'h1);
        step();
        uart_rx_valid = 1'b0;
        chk("retry push taken", 32'(uart_rx_ready), 32'h0);
        rd(A_RX, d);
        chk("retry data", d, 32'h55);
`endif

        wr(A_CLR, 32'h0);
        for (int i = 0; i < 100; i++) begin
            inst_commit = (i < 40);
            step();
        end
        inst_commit = 1'b0;
        rd(A_CYC, d);
        chk("cycle count 100", d, 32'd100);
        rd(A_INS, d);
        chk("instr count 40", d, 32'd40);
        inst_commit = 1'b1;
        rd(A_INS, d);
        chk("instr pre-update", d, 32'd40);
        inst_commit = 1'b0;
        rd(A_INS, d);
        chk("instr post-update", d, 32'd41);
        inst_commit = 1'b1;
        wr(A_CLR, 32'h0);
        inst_commit = 1'b0;
        rd(A_CYC, d);
        chk("cycle cleared", d, 32'h0);
        rd(A_INS, d);
        chk("instr cleared", d, 32'h0);

        force dut.cyc_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cyc_cnt;
        rd(A_CYC, d);
        chk("cycle at max", d, 32'hFFFF_FFFF);
        rd(A_CYC, d);
        chk("cycle wrapped", d, 32'h0);

        wr(A_TX, 32'h5A);
        chk("tx pending pre-reset", 32'(uart_tx_valid), 32'h1);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        rd(A_ST, d);
        chk("status pre-reset", d, 32'h2);
        // Handshakes offered on both sides during reset must not complete.
        rst           = 1'b1;
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h77;
        uart_tx_ready = 1'b1;
        step();
        step();
        uart_rx_valid = 1'b0;
        uart_tx_ready = 1'b0;
        rst           = 1'b0;
        chk("mid reset tx_valid", 32'(uart_tx_valid), 32'h0);
        chk("mid reset tx_data", 32'(uart_tx_data), 32'h0);
        chk("mid reset rdata", io_rdata, 32'h0);
        chk("mid reset rx_ready", 32'(uart_rx_ready), 32'h1);
        rd(A_ST, d);
        chk("status post-reset", d, 32'h1);
        rd(A_RX, d);
        chk("rx post-reset", d, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
